secded_monitor: RTL and testbench

Parametrised, multi-channel successor to the single-syndrome Hsiao SECDED analyzer. Each cycle it classifies up to NCH syndromes as no-error, correctable (CE) or uncorrectable (UE) and registers the result. It also keeps saturating CE/UE event counters and a sticky log of the first uncorrectable event, and raises a level interrupt. It sits beside the memory and register-file ECC decoders and feeds the fault-management CSRs.

---
 rtl/secded_monitor_if.sv | 34 +++
 rtl/secded_monitor.sv | 128 ++++++++++++
 tb/tb_secded_monitor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/secded_monitor_if.sv
// Bus bundle for secded_monitor: syndrome inputs, clear pulse, flags, counters and UE log.
// The monitor takes the slave modport; the ECC front-end or a bench takes master.
interface secded_monitor_if #(
    parameter int unsigned SYN_W = 7,
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       s_valid_i;
    logic [NCH*SYN_W-1:0] s_syndrome_i;
    logic                 s_clear_i;
    logic [NCH-1:0]       s_error_o;
    logic [NCH-1:0]       s_ce_o;
    logic [NCH-1:0]       s_ue_o;
    logic [CNT_W-1:0]     s_ce_cnt_o;
    logic [CNT_W-1:0]     s_ue_cnt_o;
    logic                 s_log_valid_o;
    logic [CH_W-1:0]      s_log_ch_o;
    logic [SYN_W-1:0]     s_log_syn_o;
    logic                 s_irq_o;

    modport master (
        output s_valid_i, s_syndrome_i, s_clear_i,
        input  s_error_o, s_ce_o, s_ue_o, s_ce_cnt_o, s_ue_cnt_o,
        input  s_log_valid_o, s_log_ch_o, s_log_syn_o, s_irq_o
    );

    modport slave (
        input  s_valid_i, s_syndrome_i, s_clear_i,
        output s_error_o, s_ce_o, s_ue_o, s_ce_cnt_o, s_ue_cnt_o,
        output s_log_valid_o, s_log_ch_o, s_log_syn_o, s_irq_o
    );
endinterface

// File: rtl/secded_monitor.sv
// Multi-channel Hsiao SECDED syndrome monitor: CE/UE flags, saturating counters and a sticky
// first-UE log with level interrupt; the log exists only when SECDED_MONITOR_LOG_EN is defined.
module secded_monitor #(
    parameter int unsigned SYN_W     = 7,
    parameter int unsigned NCH       = 2,
    parameter int unsigned MAX_COL_W = 3,
    parameter int unsigned CNT_W     = 16
) (
    input logic             s_clk_i,
    input logic             s_resetn_i,
    secded_monitor_if.slave bus
);
    localparam int unsigned INC_W = $clog2(NCH + 1);
    localparam int unsigned SUM_W = CNT_W + INC_W;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [NCH-1:0]   ce_d, ue_d, ce_q, ue_q;
    logic [INC_W-1:0] ce_inc, ue_inc;
    logic [CNT_W-1:0] ce_cnt_d, ue_cnt_d, ce_cnt_q, ue_cnt_q;
    int unsigned      w;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [INC_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        return (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    endfunction

    // Odd weight up to the widest H column is a single-bit error; anything else nonzero is UE.
    always_comb begin
        ce_d = '0;
        ue_d = '0;
        w    = 0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w = $countones(bus.s_syndrome_i[c*SYN_W +: SYN_W]);
            if (bus.s_valid_i[c] && (w != 0)) begin
                if ((w % 2 == 1) && (w <= MAX_COL_W)) begin
                    ce_d[c] = 1'b1;
                end else begin
                    ue_d[c] = 1'b1;
                end
            end
        end
    end

    // A same-cycle clear zeroes the base, so the counters load exactly this cycle's counts.
    always_comb begin
        ce_inc   = INC_W'($countones(ce_d));
        ue_inc   = INC_W'($countones(ue_d));
        ce_cnt_d = sat_add(bus.s_clear_i ? '0 : ce_cnt_q, ce_inc);
        ue_cnt_d = sat_add(bus.s_clear_i ? '0 : ue_cnt_q, ue_inc);
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            ce_q     <= '0;
            ue_q     <= '0;
            ce_cnt_q <= '0;
            ue_cnt_q <= '0;
        end else begin
            ce_q     <= ce_d;
            ue_q     <= ue_d;
            ce_cnt_q <= ce_cnt_d;
            ue_cnt_q <= ue_cnt_d;
        end
    end

    assign bus.s_error_o  = ce_q | ue_q;
    assign bus.s_ce_o     = ce_q;
    assign bus.s_ue_o     = ue_q;
    assign bus.s_ce_cnt_o = ce_cnt_q;
    assign bus.s_ue_cnt_o = ue_cnt_q;

`ifdef SECDED_MONITOR_LOG_EN
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             log_valid_d, log_valid_q;
    logic [CH_W-1:0]  log_ch_d, log_ch_q, ue_ch;
    logic [SYN_W-1:0] log_syn_d, log_syn_q, ue_syn;

    // Scan downwards so the lowest-index UE channel is the one that sticks.
    always_comb begin
        ue_ch  = '0;
        ue_syn = '0;
        for (int c = int'(NCH) - 1; c >= 0; c--) begin
            if (ue_d[c]) begin
                ue_ch  = CH_W'(c);
                ue_syn = bus.s_syndrome_i[c*SYN_W +: SYN_W];
            end
        end
        log_valid_d = log_valid_q;
        log_ch_d    = log_ch_q;
        log_syn_d   = log_syn_q;
        if (bus.s_clear_i) begin
            log_valid_d = 1'b0;
            log_ch_d    = '0;
            log_syn_d   = '0;
        end
        if (!log_valid_d && (|ue_d)) begin
            log_valid_d = 1'b1;
            log_ch_d    = ue_ch;
            log_syn_d   = ue_syn;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            log_valid_q <= 1'b0;
            log_ch_q    <= '0;
            log_syn_q   <= '0;
        end else begin
            log_valid_q <= log_valid_d;
            log_ch_q    <= log_ch_d;
            log_syn_q   <= log_syn_d;
        end
    end

    assign bus.s_log_valid_o = log_valid_q;
    assign bus.s_log_ch_o    = log_ch_q;
    assign bus.s_log_syn_o   = log_syn_q;
    assign bus.s_irq_o       = log_valid_q;
`else
    assign bus.s_log_valid_o = 1'b0;
    assign bus.s_log_ch_o    = '0;
    assign bus.s_log_syn_o   = '0;
    assign bus.s_irq_o       = 1'b0;
`endif
endmodule

// File: tb/tb_secded_monitor.sv
// Bench for secded_monitor: directed vector table, async reset checks, CNT_W=4 saturation
// twin, and randomized traffic against a popcount-based reference model.
module tb_secded_monitor;
    localparam int SYN_W = 7;
    localparam int NCH   = 2;
`ifdef SECDED_MONITOR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    secded_monitor_if #(.SYN_W(7), .NCH(2), .CNT_W(16)) ifm ();
    secded_monitor_if #(.SYN_W(7), .NCH(2), .CNT_W(4))  ifs ();

    assign ifs.s_valid_i    = ifm.s_valid_i;
    assign ifs.s_syndrome_i = ifm.s_syndrome_i;
    assign ifs.s_clear_i    = ifm.s_clear_i;

    secded_monitor #(.SYN_W(7), .NCH(2), .MAX_COL_W(3), .CNT_W(16)) dut (
        .s_clk_i   (clk),
        .s_resetn_i(rst_n),
        .bus       (ifm)
    );

    secded_monitor #(.SYN_W(7), .NCH(2), .MAX_COL_W(3), .CNT_W(4)) dut_sat (
        .s_clk_i   (clk),
        .s_resetn_i(rst_n),
        .bus       (ifs)
    );

    // Reference model state
    logic [1:0] m_ce, m_ue;
    int         m_ce_cnt, m_ue_cnt, s_ce_cnt, s_ue_cnt;
    bit         m_log_v;
    int         m_log_ch, m_log_syn;

    typedef struct packed {
        logic [1:0]  v;
        logic [13:0] syn;
        logic        clr;
        logic [1:0]  ce;
        logic [1:0]  ue;
        int          ce_cnt;
        int          ue_cnt;
        logic        lv;
        int          lch;
        int          lsyn;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int classify(input logic [6:0] s);
        int wt = 0;
        for (int b = 0; b < SYN_W; b++) wt += int'(s[b]);
        if (wt == 0) return 0;
        if ((wt % 2 == 1) && (wt <= 3)) return 1;
        return 2;
    endfunction

    function automatic int clip(input int val, input int maxv);
        return (val > maxv) ? maxv : val;
    endfunction

    task automatic model_reset();
        m_ce = '0; m_ue = '0;
        m_ce_cnt = 0; m_ue_cnt = 0; s_ce_cnt = 0; s_ue_cnt = 0;
        m_log_v = 1'b0; m_log_ch = 0; m_log_syn = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".error"}, 32'(ifm.s_error_o), 32'(m_ce | m_ue));
        check({tag, ".ce"}, 32'(ifm.s_ce_o), 32'(m_ce));
        check({tag, ".ue"}, 32'(ifm.s_ue_o), 32'(m_ue));
        check({tag, ".ce_cnt"}, 32'(ifm.s_ce_cnt_o), 32'(m_ce_cnt));
        check({tag, ".ue_cnt"}, 32'(ifm.s_ue_cnt_o), 32'(m_ue_cnt));
        check({tag, ".log_valid"}, 32'(ifm.s_log_valid_o), LOG_EN ? 32'(m_log_v) : 0);
        check({tag, ".log_ch"}, 32'(ifm.s_log_ch_o), LOG_EN ? 32'(m_log_ch) : 0);
        check({tag, ".log_syn"}, 32'(ifm.s_log_syn_o), LOG_EN ? 32'(m_log_syn) : 0);
        check({tag, ".irq"}, 32'(ifm.s_irq_o), LOG_EN ? 32'(m_log_v) : 0);
        check({tag, ".sat_ce"}, 32'(ifs.s_ce_o), 32'(m_ce));
        check({tag, ".sat_ue"}, 32'(ifs.s_ue_o), 32'(m_ue));
        check({tag, ".sat_ce_cnt"}, 32'(ifs.s_ce_cnt_o), 32'(s_ce_cnt));
        check({tag, ".sat_ue_cnt"}, 32'(ifs.s_ue_cnt_o), 32'(s_ue_cnt));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".error"}, 32'(ifm.s_error_o), 0);
        check({tag, ".ce_cnt"}, 32'(ifm.s_ce_cnt_o), 0);
        check({tag, ".ue_cnt"}, 32'(ifm.s_ue_cnt_o), 0);
        check({tag, ".log_valid"}, 32'(ifm.s_log_valid_o), 0);
        check({tag, ".log_syn"}, 32'(ifm.s_log_syn_o), 0);
        check({tag, ".irq"}, 32'(ifm.s_irq_o), 0);
        check({tag, ".sat_ce_cnt"}, 32'(ifs.s_ce_cnt_o), 0);
    endtask

    task automatic step(input logic [1:0] v, input logic [13:0] syn, input logic clr,
                        input string tag);
        int         ce_n, ue_n, first, k;
        logic [1:0] cf, uf;
        @(negedge clk);
        ifm.s_valid_i    = v;
        ifm.s_syndrome_i = syn;
        ifm.s_clear_i    = clr;
        ce_n = 0; ue_n = 0; first = -1; cf = '0; uf = '0;
        for (int c = 0; c < NCH; c++) begin
            k = v[c] ? classify(syn[c*SYN_W +: SYN_W]) : 0;
            if (k == 1) begin cf[c] = 1'b1; ce_n++; end
            if (k == 2) begin
                uf[c] = 1'b1; ue_n++;
                if (first < 0) first = c;
            end
        end
        @(posedge clk);
        #1;
        if (clr) begin
            m_ce_cnt = 0; m_ue_cnt = 0; s_ce_cnt = 0; s_ue_cnt = 0;
            m_log_v = 1'b0; m_log_ch = 0; m_log_syn = 0;
        end
        m_ce_cnt = clip(m_ce_cnt + ce_n, 65535);
        m_ue_cnt = clip(m_ue_cnt + ue_n, 65535);
        s_ce_cnt = clip(s_ce_cnt + ce_n, 15);
        s_ue_cnt = clip(s_ue_cnt + ue_n, 15);
        if (!m_log_v && first >= 0) begin
            m_log_v   = 1'b1;
            m_log_ch  = first;
            m_log_syn = int'(syn[first*SYN_W +: SYN_W]);
        end
        m_ce = cf;
        m_ue = uf;
        compare_all(tag);
    endtask

    function automatic logic [6:0] rand_syn();
        case ($urandom_range(0, 3))
            0: return 7'h00;
            1: return 7'(1 << $urandom_range(0, 6));
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        tbl[0] = '{2'b01, {7'h00, 7'b0000100}, 1'b0, 2'b01, 2'b00, 1, 0, 1'b0, 0, 0};
        tbl[1] = '{2'b01, {7'h00, 7'b0001011}, 1'b0, 2'b01, 2'b00, 2, 0, 1'b0, 0, 0};
        tbl[2] = '{2'b01, {7'h00, 7'b0011111}, 1'b0, 2'b00, 2'b01, 2, 1, 1'b1, 0, 'h1F};
        tbl[3] = '{2'b00, {7'h00, 7'h00},      1'b1, 2'b00, 2'b00, 0, 0, 1'b0, 0, 0};
        tbl[4] = '{2'b11, {7'h7F, 7'h03},      1'b0, 2'b00, 2'b11, 0, 2, 1'b1, 0, 'h03};
        tbl[5] = '{2'b10, {7'h30, 7'h00},      1'b0, 2'b00, 2'b10, 0, 3, 1'b1, 0, 'h03};
        tbl[6] = '{2'b10, {7'h01, 7'h00},      1'b0, 2'b10, 2'b00, 1, 3, 1'b1, 0, 'h03};
        tbl[7] = '{2'b10, {7'h30, 7'h00},      1'b1, 2'b00, 2'b10, 0, 1, 1'b1, 1, 'h30};
        tbl[8] = '{2'b00, {7'h7F, 7'h7F},      1'b0, 2'b00, 2'b00, 0, 1, 1'b1, 1, 'h30};

        ifm.s_valid_i = '0; ifm.s_syndrome_i = '0; ifm.s_clear_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) step(2'b00, 14'h0, 1'b0, "idle");

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].syn, tbl[i].clr, $sformatf("vec%0d", i));
            check($sformatf("tbl%0d.ce", i), 32'(ifm.s_ce_o), 32'(tbl[i].ce));
            check($sformatf("tbl%0d.ue", i), 32'(ifm.s_ue_o), 32'(tbl[i].ue));
            check($sformatf("tbl%0d.ce_cnt", i), 32'(ifm.s_ce_cnt_o), tbl[i].ce_cnt);
            check($sformatf("tbl%0d.ue_cnt", i), 32'(ifm.s_ue_cnt_o), tbl[i].ue_cnt);
            check($sformatf("tbl%0d.log_valid", i), 32'(ifm.s_log_valid_o),
                  LOG_EN ? 32'(tbl[i].lv) : 0);
            check($sformatf("tbl%0d.log_ch", i), 32'(ifm.s_log_ch_o), LOG_EN ? tbl[i].lch : 0);
            check($sformatf("tbl%0d.log_syn", i), 32'(ifm.s_log_syn_o),
                  LOG_EN ? tbl[i].lsyn : 0);
            check($sformatf("tbl%0d.irq", i), 32'(ifm.s_irq_o), LOG_EN ? 32'(tbl[i].lv) : 0);
        end

        // Both channels CE for 20 cycles: the CNT_W=4 twin must pin at 15.
        for (int i = 0; i < 20; i++) step(2'b11, {7'h40, 7'h02}, 1'b0, "sat");
        check("sat_final", 32'(ifs.s_ce_cnt_o), 15);
        check("wide_final", 32'(ifm.s_ce_cnt_o), 40);

        for (int i = 0; i < 300; i++) begin
            step(2'($urandom), {rand_syn(), rand_syn()}, ($urandom_range(0, 19) == 0),
                 "rand");
        end

        // Asynchronous reset mid-cycle with a UE in flight: dropped, never counted or logged.
        @(negedge clk);
        ifm.s_valid_i = 2'b01; ifm.s_syndrome_i = {7'h00, 7'h03}; ifm.s_clear_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        @(negedge clk);
        ifm.s_valid_i = '0; ifm.s_syndrome_i = '0;
        rst_n = 1'b1;
        model_reset();
        step(2'b00, 14'h0, 1'b0, "post_rst");
        step(2'b01, {7'h00, 7'h03}, 1'b0, "post_rst_ue");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
